// File: rtl/led_indicator.sv
// Per-channel LED blinker: turns each single-cycle event pulse into BLINKS
// lit phases of ON_CYCLES separated by dark gaps of OFF_CYCLES.
module led_indicator #(
    parameter int WIDTH        = 1,
    parameter bit POLARITY     = 1'b1,
    parameter int COUNTER_BITS = 24,
    parameter int ON_CYCLES    = 5000000,
    parameter int OFF_CYCLES   = 5000000,
    parameter int BLINKS       = 2,
    parameter int BLINK_BITS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] event_pulse,
    output logic [WIDTH-1:0] led_out,
    output logic [WIDTH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [COUNTER_BITS-1:0] ON_LAST  = COUNTER_BITS'(ON_CYCLES - 1);
    localparam logic [COUNTER_BITS-1:0] OFF_LAST = COUNTER_BITS'(OFF_CYCLES - 1);
    localparam logic [BLINK_BITS-1:0]   REM_INIT = BLINK_BITS'(BLINKS - 1);
    localparam logic                    LIT      = POLARITY;
    localparam logic                    DARK     = ~POLARITY;

    // Packed copy of every channel's state, kept for probing from a bench or checker.
    logic [2*WIDTH-1:0] state_dbg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t                  state;
        logic [COUNTER_BITS-1:0] cnt;
        logic [BLINK_BITS-1:0]   rem;
        logic                    led_q;
        logic                    busy_q;

        // Outputs are written alongside the next state so they move on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                rem    <= '0;
                led_q  <= DARK;
                busy_q <= 1'b0;
            end else if (event_pulse[i]) begin
                // A pulse in any state (re)starts the pattern, beating terminal counts.
                state  <= ON;
                cnt    <= '0;
                rem    <= REM_INIT;
                led_q  <= LIT;
                busy_q <= 1'b1;
            end else begin
                case (state)
                    ON: begin
                        if (cnt == ON_LAST) begin
                            cnt <= '0;
                            if (rem == '0) begin
                                state  <= IDLE;
                                led_q  <= DARK;
                                busy_q <= 1'b0;
                            end else begin
                                state  <= OFF;
                                led_q  <= DARK;
                                busy_q <= 1'b1;
                            end
                        end else begin
                            cnt    <= cnt + 1'b1;
                            led_q  <= LIT;
                            busy_q <= 1'b1;
                        end
                    end
                    OFF: begin
                        if (cnt == OFF_LAST) begin
                            state  <= ON;
                            cnt    <= '0;
                            rem    <= rem - 1'b1;
                            led_q  <= LIT;
                            busy_q <= 1'b1;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            led_q  <= DARK;
                            busy_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        led_q  <= DARK;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign led_out[i]           = led_q;
        assign busy[i]              = busy_q;
        assign state_dbg[2*i +: 2] = state;
    end

endmodule
